// File: rtl/umi_msg_arbiter_pkg.sv
// Shared UMI definitions: command field offsets, the cmd unpack helper and
// the arbiter state encoding.
package umi_msg_arbiter_pkg;

    localparam int UMI_CMD_W      = 32;
    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_SIZE_LSB   = 5;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_QOS_LSB    = 16;
    localparam int UMI_PROT_LSB   = 20;
    localparam int UMI_EOM_BIT    = 22;
    localparam int UMI_EOF_BIT    = 23;
    localparam int UMI_EX_BIT     = 24;
    localparam int UMI_USER_LSB   = 25;
    localparam int UMI_HOSTID_LSB = 27;

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] size;
        logic [7:0] len;
        logic [3:0] qos;
        logic [1:0] prot;
        logic       eom;
        logic       eof;
        logic       ex;
        logic [1:0] user;
        logic [4:0] hostid;
    } umi_cmd_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic umi_cmd_t umi_unpack(input logic [UMI_CMD_W-1:0] cmd);
        umi_cmd_t f;
        f.opcode = cmd[UMI_OPCODE_LSB +: 5];
        f.size   = cmd[UMI_SIZE_LSB +: 3];
        f.len    = cmd[UMI_LEN_LSB +: 8];
        f.qos    = cmd[UMI_QOS_LSB +: 4];
        f.prot   = cmd[UMI_PROT_LSB +: 2];
        f.eom    = cmd[UMI_EOM_BIT];
        f.eof    = cmd[UMI_EOF_BIT];
        f.ex     = cmd[UMI_EX_BIT];
        f.user   = cmd[UMI_USER_LSB +: 2];
        f.hostid = cmd[UMI_HOSTID_LSB +: 5];
        return f;
    endfunction

endpackage

// File: rtl/umi_msg_arbiter_rr_select.sv
// Combinational requester select: round-robin from a pointer or fixed
// priority (index 0 highest). Shared by UMI arbiters.
module umi_rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] rr_ptr_i,
    input  logic          arb_mode_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    // With nothing valid the index still reports the pointer (RR) or 0 (fixed).
    always_comb begin
        logic          found;
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        idx_o = arb_mode_i ? '0 : rr_ptr_i;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = arb_mode_i ? IW'(k) : sum[IW-1:0];
            if (!found && valid_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant_o[gi] = valid_i[gi] & (idx_o == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/umi_msg_arbiter.sv
// Packet-atomic N-to-1 UMI arbiter: the grant is held from the first beat of
// a message until its eom beat, so messages never interleave at the sink.
module umi_msg_arbiter
    import umi_msg_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
) (
    input  logic                    umi_in_clk,
    input  logic                    nreset,
    input  logic                    arb_mode,
    input  logic [N-1:0]            umi_in_valid,
    input  logic [N*CW-1:0]         umi_in_cmd,
    input  logic [N*AW-1:0]         umi_in_dstaddr,
    input  logic [N*AW-1:0]         umi_in_srcaddr,
    input  logic [N*DW-1:0]         umi_in_data,
    output logic [N-1:0]            umi_in_ready,
    output logic                    umi_out_valid,
    output logic [CW-1:0]           umi_out_cmd,
    output logic [AW-1:0]           umi_out_dstaddr,
    output logic [AW-1:0]           umi_out_srcaddr,
    output logic [DW-1:0]           umi_out_data,
    input  logic                    umi_out_ready,
    output logic [$clog2(N)-1:0]    arb_owner,
    output logic                    arb_locked
);

    localparam int IW = $clog2(N);

    arb_state_e    state_q;
    logic          locked_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] lock_owner_q;

    logic [N-1:0]  rs_grant;
    logic [IW-1:0] rs_idx;
    logic [IW-1:0] sel;
    logic [IW-1:0] ptr_d;
    logic          beat;
    logic          out_eom;
    umi_cmd_t      out_fields;
    logic          unused_cmd_fields;

    logic [CW-1:0] cmd_arr [N];
    logic [AW-1:0] dst_arr [N];
    logic [AW-1:0] src_arr [N];
    logic [DW-1:0] data_arr [N];

    umi_rr_select #(
        .N  (N),
        .IW (IW)
    ) u_select (
        .valid_i    (umi_in_valid),
        .rr_ptr_i   (rr_ptr_q),
        .arb_mode_i (arb_mode),
        .grant_o    (rs_grant),
        .idx_o      (rs_idx)
    );

    assign sel = (state_q == ARB_LOCKED) ? lock_owner_q : rs_idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lanes
            assign cmd_arr[gi]  = umi_in_cmd[gi*CW +: CW];
            assign dst_arr[gi]  = umi_in_dstaddr[gi*AW +: AW];
            assign src_arr[gi]  = umi_in_srcaddr[gi*AW +: AW];
            assign data_arr[gi] = umi_in_data[gi*DW +: DW];
            // While locked the owner sees ready even with valid low, so the
            // grant stays pinned to it; in IDLE only the granted valid is ready.
            assign umi_in_ready[gi] = umi_out_ready &
                ((state_q == ARB_LOCKED) ? (lock_owner_q == IW'(gi)) : rs_grant[gi]);
        end
    endgenerate

    assign umi_out_valid   = umi_in_valid[sel];
    assign umi_out_cmd     = cmd_arr[sel];
    assign umi_out_dstaddr = dst_arr[sel];
    assign umi_out_srcaddr = src_arr[sel];
    assign umi_out_data    = data_arr[sel];
    assign arb_owner       = sel;
    assign arb_locked      = locked_q;

    assign out_fields        = umi_unpack(umi_out_cmd[UMI_CMD_W-1:0]);
    assign out_eom           = out_fields.eom;
    assign unused_cmd_fields = ^out_fields;

    assign beat  = umi_out_valid & umi_out_ready;
    assign ptr_d = (sel == IW'(N-1)) ? '0 : sel + 1'b1;

    always_ff @(posedge umi_in_clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ARB_IDLE;
            locked_q     <= 1'b0;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
        end else if (beat) begin
            if (out_eom) begin
                rr_ptr_q <= ptr_d;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (!out_eom) begin
                        state_q      <= ARB_LOCKED;
                        locked_q     <= 1'b1;
                        lock_owner_q <= sel;
                    end
                end
                ARB_LOCKED: begin
                    if (out_eom) begin
                        state_q  <= ARB_IDLE;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ARB_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umi_msg_arbiter.sv
// Self-checking bench for umi_msg_arbiter: per-cycle comparison against a
// message-level model plus directed scenarios with literal expectations.
module tb_umi_msg_arbiter;

    localparam int N   = 4;
    localparam int CW  = 32;
    localparam int AW  = 64;
    localparam int DW  = 256;
    localparam int EOM = 22;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              arb_mode = 1'b0;
    logic [N-1:0]      in_valid = '0;
    logic [N*CW-1:0]   in_cmd = '0;
    logic [N*AW-1:0]   in_dst = '0;
    logic [N*AW-1:0]   in_src = '0;
    logic [N*DW-1:0]   in_data = '0;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [CW-1:0]     out_cmd;
    logic [AW-1:0]     out_dst;
    logic [AW-1:0]     out_src;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic [1:0]        arb_owner;
    logic              arb_locked;

    int checks = 0;
    int errors = 0;
    int dut_beats[$];

    bit m_locked;
    int m_owner;
    int m_ptr;

    umi_msg_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
        .umi_in_clk      (clk),
        .nreset          (nreset),
        .arb_mode        (arb_mode),
        .umi_in_valid    (in_valid),
        .umi_in_cmd      (in_cmd),
        .umi_in_dstaddr  (in_dst),
        .umi_in_srcaddr  (in_src),
        .umi_in_data     (in_data),
        .umi_in_ready    (in_ready),
        .umi_out_valid   (out_valid),
        .umi_out_cmd     (out_cmd),
        .umi_out_dstaddr (out_dst),
        .umi_out_srcaddr (out_src),
        .umi_out_data    (out_data),
        .umi_out_ready   (out_ready),
        .arb_owner       (arb_owner),
        .arb_locked      (arb_locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who owns the sink this cycle, from message rules alone.
    function automatic int exp_sel();
        if (m_locked) return m_owner;
        if (arb_mode) begin
            for (int i = 0; i < N; i++) if (in_valid[i]) return i;
            return 0;
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (in_valid[j]) return j;
        end
        return m_ptr;
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_ptr    <= 0;
        end else begin
            int s;
            s = exp_sel();
            if (in_valid[s] && out_ready) begin
                if (in_cmd[s*CW + EOM]) begin
                    m_locked <= 1'b0;
                    m_ptr    <= (s + 1) % N;
                end else if (!m_locked) begin
                    m_locked <= 1'b1;
                    m_owner  <= s;
                end
            end
        end
    end

    always @(negedge clk) begin
        int s;
        logic [N-1:0] er;
        s = exp_sel();
        er = '0;
        if (out_ready && (m_locked || in_valid[s])) er[s] = 1'b1;
        check("owner", 256'(arb_owner), 256'(s));
        check("out_valid", 256'(out_valid), 256'(in_valid[s]));
        check("locked", 256'(arb_locked), 256'(m_locked));
        check("in_ready", 256'(in_ready), 256'(er));
        if (in_valid[s]) begin
            check("out_cmd", 256'(out_cmd), 256'(in_cmd[s*CW +: CW]));
            check("out_dst", 256'(out_dst), 256'(in_dst[s*AW +: AW]));
            check("out_src", 256'(out_src), 256'(in_src[s*AW +: AW]));
            check("out_data", out_data, in_data[s*DW +: DW]);
        end
        if (nreset && out_valid && out_ready) begin
            dut_beats.push_back(int'(arb_owner));
            $display("beat owner=%0d cmd=%08h locked=%0b t=%0t", arb_owner, out_cmd, arb_locked, $time);
        end
    end

    task automatic set_req(input int i, input bit v, input bit eom, input logic [7:0] tag);
        logic [CW-1:0] c;
        c = 32'h1 | (32'(tag) << 8);
        c[EOM] = eom;
        in_valid[i] = v;
        in_cmd[i*CW +: CW]  = c;
        in_dst[i*AW +: AW]  = {32'hD000_0000 | 32'(i), 24'h0, tag};
        in_src[i*AW +: AW]  = {32'h5000_0000 | 32'(i), 24'h0, tag};
        in_data[i*DW +: DW] = {8{tag, 8'(i), 16'hA5A5}};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected owners packed as hex nibbles, first beat in the most significant.
    task automatic check_beats(input string name, input int cnt, input logic [63:0] owners);
        check({name, "_count"}, 256'(dut_beats.size()), 256'(cnt));
        for (int k = 0; k < cnt && k < dut_beats.size(); k++) begin
            check({name, "_owner"}, 256'(dut_beats[k]), 256'(owners[4*(cnt-1-k) +: 4]));
        end
        dut_beats.delete();
    endtask

    initial begin
        #2;
        check("rst_locked", 256'(arb_locked), 256'(0));
        check("rst_owner", 256'(arb_owner), 256'(0));
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_ready", 256'(in_ready), 256'(0));
        step();
        step();
        nreset = 1'b1;
        out_ready = 1'b1;

        // Single requester 2, three single-packet messages.
        set_req(2, 1, 1, 8'h10); step();
        set_req(2, 1, 1, 8'h11); step();
        set_req(2, 1, 1, 8'h12); step();
        set_req(2, 0, 0, 8'h00);
        #1;
        check("t1_ptr", 256'(arb_owner), 256'(3));
        check("t1_locked", 256'(arb_locked), 256'(0));
        check_beats("t1", 3, 64'h222);
        step();

        // Bring rr_ptr to 0, then all valid: 0,1,2,3,0.
        set_req(3, 1, 1, 8'h20); step();
        check_beats("t2a", 1, 64'h3);
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 8'h21);
        repeat (5) step();
        check_beats("t2", 5, 64'h01230);
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 8'h00);

        // Three-packet message from req 1 with req 0 and 3 contending.
        set_req(0, 1, 1, 8'h30);
        set_req(3, 1, 1, 8'h30);
        set_req(1, 1, 0, 8'h31); step();
        check("t3_lock_c2", 256'(arb_locked), 256'(1));
        set_req(1, 1, 0, 8'h32); step();
        check("t3_lock_c3", 256'(arb_locked), 256'(1));
        set_req(1, 1, 1, 8'h33); step();
        check("t3_unlock", 256'(arb_locked), 256'(0));
        set_req(1, 0, 0, 8'h00); step();
        check_beats("t3", 4, 64'h1113);
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 8'h00);

        // Owner 1 drops valid mid-message for 4 cycles.
        set_req(1, 1, 0, 8'h41); step();
        set_req(1, 0, 0, 8'h00);
        set_req(0, 1, 1, 8'h40);
        set_req(2, 1, 1, 8'h40);
        set_req(3, 1, 1, 8'h40);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4_valid", 256'(out_valid), 256'(0));
            check("t4_others", 256'(in_ready & 4'b1101), 256'(0));
            check("t4_owner", 256'(arb_owner), 256'(1));
            step();
        end
        set_req(1, 1, 1, 8'h42); step();
        set_req(1, 0, 0, 8'h00);
        set_req(0, 0, 0, 8'h00);
        set_req(3, 0, 0, 8'h00);
        set_req(2, 1, 0, 8'h51); step();
        check_beats("t4", 3, 64'h112);

        // Sink stalls for 5 cycles while locked on req 2.
        out_ready = 1'b0;
        set_req(2, 1, 0, 8'h52);
        for (int c = 0; c < 5; c++) begin
            set_req(0, 1, 1, 8'(8'h60 + c));
            set_req(3, 1, 1, 8'(8'h70 + c));
            #1;
            check("t5_cmd", 256'(out_cmd), 256'(32'h0000_5201));
            check("t5_locked", 256'(arb_locked), 256'(1));
            check("t5_owner", 256'(arb_owner), 256'(2));
            check("t5_ready", 256'(in_ready), 256'(0));
            step();
        end
        check_beats("t5_stall", 0, 64'h0);
        out_ready = 1'b1;
        step();
        check_beats("t5", 1, 64'h2);

        // Reset while locked on req 2; rr_ptr (2) must clear at once.
        nreset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 8'h00);
        arb_mode = 1'b0;
        #1;
        check("t6_locked", 256'(arb_locked), 256'(0));
        check("t6_ptr", 256'(arb_owner), 256'(0));
        arb_mode = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 8'h80);
        step();
        step();
        nreset = 1'b1;
        step();
        step();
        check_beats("t6", 2, 64'h00);
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 8'h00);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
